accel_issue_ctrl: RTL

ACCEL_ISSUE_CTRL -- requirements
Module: accel_issue_ctrl

---
 rtl/accel_issue_pkg.sv | 19 +
 rtl/accel_issue_timer.sv | 40 ++++
 rtl/accel_issue_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/accel_issue_pkg.sv
// Shared types and default widths for the accelerator issue controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package accel_issue_pkg;

    // Default widths for operand/result data, ROB tag and control immediate
    localparam int DATA_W_DEF = 64;
    localparam int TAG_W_DEF  = 4;
    localparam int CTL_W_DEF  = 8;

    // One operation moves IDLE -> REQ -> WAIT_RESP -> WB -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_WB        = 2'd3
    } state_e;

endpackage

// File: rtl/accel_issue_timer.sv
// Response-wait counter: counts cycles while enabled and flags the last allowed cycle.
// Latency: expired_o is registered-count decode, valid in the cycle the count reaches LIMIT-1.
// Backpressure: none; the counter saturates at LIMIT-1 until cleared.
module accel_issue_timer #(
    parameter int LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));

    // Hold at zero while cleared, otherwise count up and saturate at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/accel_issue_ctrl.sv
// Single-outstanding accelerator issue controller: issue -> accelerator req -> response -> CDB writeback.
// Latency: issue in cycle N gives acc_valid_o in N+1 and, with no stalls, cdb_valid_o in N+3.
// Backpressure: holds acc request and CDB writeback stable until accepted; issue_ready_o only in IDLE.
// Build option: define ACCEL_ISSUE_TIMEOUT_EN to add the response timeout (TIMEOUT_CYCLES).
module accel_issue_ctrl
    import accel_issue_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TAG_W          = TAG_W_DEF,
    parameter int CTL_W          = CTL_W_DEF,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [DATA_W-1:0] issue_data_i,
    input  logic [CTL_W-1:0]  issue_ctl_i,
    input  logic [TAG_W-1:0]  issue_tag_i,
    output logic              acc_valid_o,
    input  logic              acc_ready_i,
    output logic [DATA_W-1:0] acc_data_o,
    output logic [CTL_W-1:0]  acc_ctl_o,
    input  logic              acc_resp_valid_i,
    output logic              acc_resp_ready_o,
    input  logic [DATA_W-1:0] acc_resp_data_i,
    output logic              cdb_valid_o,
    input  logic              cdb_ready_i,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [TAG_W-1:0]  cdb_tag_o,
    output logic              cdb_except_o,
    output logic              busy_o
);

    state_e state_q;
    state_e state_d;

    // Handshake outputs are flops loaded from the next-state decode
    logic issue_ready_q, issue_ready_d;
    logic acc_valid_q, acc_valid_d;
    logic acc_resp_ready_q, acc_resp_ready_d;
    logic cdb_valid_q, cdb_valid_d;
    logic busy_q, busy_d;

    logic [DATA_W-1:0] op_data_q, op_data_d;
    logic [CTL_W-1:0]  op_ctl_q, op_ctl_d;
    logic [TAG_W-1:0]  op_tag_q, op_tag_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

    logic timeout;

`ifdef ACCEL_ISSUE_TIMEOUT_EN
    logic timer_expired;
    logic except_q, except_d;

    // Counter sits at zero outside WAIT_RESP, so it starts from zero on every entry
    accel_issue_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state_q != ST_WAIT_RESP),
        .en_i      (state_q == ST_WAIT_RESP),
        .expired_o (timer_expired)
    );

    // A response arriving on the limit cycle takes precedence over the timeout
    assign timeout = (state_q == ST_WAIT_RESP) && timer_expired && !acc_resp_valid_i;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    // Next state and the registered handshake outputs it implies; flush wins over everything
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      if (issue_valid_i)               state_d = ST_REQ;
                ST_REQ:       if (acc_ready_i)                 state_d = ST_WAIT_RESP;
                ST_WAIT_RESP: if (acc_resp_valid_i || timeout) state_d = ST_WB;
                ST_WB:        if (cdb_ready_i)                 state_d = ST_IDLE;
                default:                                       state_d = ST_IDLE;
            endcase
        end
        issue_ready_d    = (state_d == ST_IDLE);
        acc_valid_d      = (state_d == ST_REQ);
        acc_resp_ready_d = (state_d == ST_WAIT_RESP);
        cdb_valid_d      = (state_d == ST_WB);
        busy_d           = (state_d != ST_IDLE);
    end

    // FSM state plus registered handshake outputs; reset lands in IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            issue_ready_q    <= 1'b1;
            acc_valid_q      <= 1'b0;
            acc_resp_ready_q <= 1'b0;
            cdb_valid_q      <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            issue_ready_q    <= issue_ready_d;
            acc_valid_q      <= acc_valid_d;
            acc_resp_ready_q <= acc_resp_ready_d;
            cdb_valid_q      <= cdb_valid_d;
            busy_q           <= busy_d;
        end
    end

    // Operand, control and tag capture only on an accepted, unflushed issue
    always_comb begin
        op_data_d = op_data_q;
        op_ctl_d  = op_ctl_q;
        op_tag_d  = op_tag_q;
        if (!flush_i && (state_q == ST_IDLE) && issue_valid_i) begin
            op_data_d = issue_data_i;
            op_ctl_d  = issue_ctl_i;
            op_tag_d  = issue_tag_i;
        end
    end

    // Result capture on an accepted response; a timeout writes back zero
    always_comb begin
        res_data_d = res_data_q;
        if (!flush_i && (state_q == ST_WAIT_RESP)) begin
            if (acc_resp_valid_i) begin
                res_data_d = acc_resp_data_i;
            end else if (timeout) begin
                res_data_d = '0;
            end
        end
    end

    // Datapath registers; flush leaves them untouched
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_data_q  <= '0;
            op_ctl_q   <= '0;
            op_tag_q   <= '0;
            res_data_q <= '0;
        end else begin
            op_data_q  <= op_data_d;
            op_ctl_q   <= op_ctl_d;
            op_tag_q   <= op_tag_d;
            res_data_q <= res_data_d;
        end
    end

`ifdef ACCEL_ISSUE_TIMEOUT_EN
    // Exception flag follows the result: set by timeout, cleared by a real response
    always_comb begin
        except_d = except_q;
        if (!flush_i && (state_q == ST_WAIT_RESP)) begin
            if (acc_resp_valid_i) begin
                except_d = 1'b0;
            end else if (timeout) begin
                except_d = 1'b1;
            end
        end
    end

    // Exception flag register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            except_q <= 1'b0;
        end else begin
            except_q <= except_d;
        end
    end

    assign cdb_except_o = except_q;
`else
    assign cdb_except_o = 1'b0;
`endif

    assign issue_ready_o    = issue_ready_q;
    assign acc_valid_o      = acc_valid_q;
    assign acc_resp_ready_o = acc_resp_ready_q;
    assign cdb_valid_o      = cdb_valid_q;
    assign busy_o           = busy_q;
    assign acc_data_o       = op_data_q;
    assign acc_ctl_o        = op_ctl_q;
    assign cdb_data_o       = res_data_q;
    assign cdb_tag_o        = op_tag_q;

endmodule
